// File: rtl/arcdp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arcdp_pkg: shared ALU opcodes, special-register map, PSR bits, FSM states  |
// | Revision: 2.0                                                              |
// +----------------------------------------------------------------------------+
package arcdp_pkg;

   typedef enum logic [3:0] {
      ALU_ANDCC    = 4'd0,
      ALU_ORCC     = 4'd1,
      ALU_NORCC    = 4'd2,
      ALU_ADDCC    = 4'd3,
      ALU_SRL      = 4'd4,
      ALU_AND      = 4'd5,
      ALU_OR       = 4'd6,
      ALU_NOR      = 4'd7,
      ALU_ADD      = 4'd8,
      ALU_LSHIFT2  = 4'd9,
      ALU_LSHIFT10 = 4'd10,
      ALU_SIMM13   = 4'd11,
      ALU_SEXT13   = 4'd12,
      ALU_INC      = 4'd13,
      ALU_INCPC    = 4'd14,
      ALU_RSHIFT5  = 4'd15
   } alu_op_e;

   localparam int unsigned ADDR_PC    = 32;
   localparam int unsigned ADDR_TEMP0 = 33;
   localparam int unsigned ADDR_TEMP1 = 34;
   localparam int unsigned ADDR_TEMP2 = 35;
   localparam int unsigned ADDR_TEMP3 = 36;
   localparam int unsigned ADDR_IR    = 37;
   localparam int unsigned ADDR_OUT   = 38;

   localparam int unsigned PSR_N = 3;
   localparam int unsigned PSR_Z = 2;
   localparam int unsigned PSR_V = 1;
   localparam int unsigned PSR_C = 0;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

endpackage
`default_nettype wire

// File: rtl/arcdp_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arcdp_alu: combinational 16-op ARC ALU producing result and {N,Z,V,C}      |
// | Revision: 2.0                                                              |
// +----------------------------------------------------------------------------+
module arcdp_alu
   import arcdp_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  alu_op_e       op_i,
   output logic [DW-1:0] result_o,
   output logic [3:0]    flags_o
);

   logic [DW:0] w_sum;
   logic        w_v;
   logic        w_c;

   assign w_sum = {1'b0, a_i} + {1'b0, b_i};

   always_comb begin
      result_o = '0;
      w_v      = 1'b0;
      w_c      = 1'b0;
      case (op_i)
         ALU_ANDCC, ALU_AND: result_o = a_i & b_i;
         ALU_ORCC,  ALU_OR:  result_o = a_i | b_i;
         ALU_NORCC, ALU_NOR: result_o = ~(a_i | b_i);
         ALU_ADDCC: begin
            result_o = w_sum[DW-1:0];
            w_c      = w_sum[DW];
            w_v      = (a_i[DW-1] == b_i[DW-1]) && (w_sum[DW-1] != a_i[DW-1]);
         end
         ALU_SRL:      result_o = a_i >> b_i[4:0];
         ALU_ADD:      result_o = w_sum[DW-1:0];
         ALU_LSHIFT2:  result_o = a_i << 2;
         ALU_LSHIFT10: result_o = a_i << 10;
         ALU_SIMM13:   result_o = {{(DW-13){1'b0}}, a_i[12:0]};
         ALU_SEXT13:   result_o = {{(DW-13){a_i[12]}}, a_i[12:0]};
         ALU_INC:      result_o = a_i + DW'(1);
         ALU_INCPC:    result_o = a_i + DW'(4);
         ALU_RSHIFT5:  result_o = $signed(a_i) >>> 5;
         default:      result_o = '0;
      endcase
   end

   always_comb begin
      flags_o        = '0;
      flags_o[PSR_N] = result_o[DW-1];
      flags_o[PSR_Z] = (result_o == '0);
      flags_o[PSR_V] = w_v;
      flags_o[PSR_C] = w_c;
   end

endmodule
`default_nettype wire

// File: rtl/arcdp_datapath_gen2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arcdp_datapath_gen2: ARC datapath with scratchpad, ALU/PSR, stalling read  |
// | Optional macro ARCDP_ALU_PIPE_EN adds a forwarded EX stage. Revision: 2.0  |
// +----------------------------------------------------------------------------+
module arcdp_datapath_gen2
   import arcdp_pkg::*;
#(
   parameter int NUM_GPR                 = 32,
   parameter int DATAWIDTH_BUS           = 32,
   parameter int DATAWIDTH_MIR_DIRECTION = 6,
   parameter int DATAWIDTH_ALU_SELECTION = 4
) (
   input  logic                               ARCDP_CLOCK_50,
   input  logic                               ARCDP_ResetInHigh_In,
   input  logic                               ARCDP_Cmd_Valid_In,
   output logic                               ARCDP_Cmd_Ready_Out,
   input  logic [DATAWIDTH_MIR_DIRECTION-1:0] ARCDP_DirA_InBus,
   input  logic [DATAWIDTH_MIR_DIRECTION-1:0] ARCDP_DirB_InBus,
   input  logic [DATAWIDTH_MIR_DIRECTION-1:0] ARCDP_DirC_InBus,
   input  logic                               ARCDP_SelectA_In,
   input  logic                               ARCDP_SelectB_In,
   input  logic                               ARCDP_SelectC_In,
   input  logic [DATAWIDTH_ALU_SELECTION-1:0] ARCDP_ALUOperation_InBus,
   input  logic                               ARCDP_RD_In,
   input  logic                               ARCDP_MemValid_In,
   input  logic [DATAWIDTH_BUS-1:0]           ARCDP_MemoryData_InBus,
   output logic                               ARCDP_MemReq_Out,
   output logic [DATAWIDTH_BUS-1:0]           ARCDP_A_OutBus,
   output logic [DATAWIDTH_BUS-1:0]           ARCDP_B_OutBus,
   output logic [3:0]                         ARCDP_PSR_OutBus,
   output logic [DATAWIDTH_BUS-1:0]           ARCDP_IR_OutBus,
   output logic [DATAWIDTH_BUS-1:0]           ARCDP_DataOut_OutBus
);

   localparam int AW = DATAWIDTH_MIR_DIRECTION;
   localparam int DW = DATAWIDTH_BUS;
   localparam int GW = $clog2(NUM_GPR);

   localparam logic [AW-1:0] c_num_gpr = AW'(NUM_GPR);
   localparam logic [AW-1:0] c_pc      = AW'(ADDR_PC);
   localparam logic [AW-1:0] c_temp0   = AW'(ADDR_TEMP0);
   localparam logic [AW-1:0] c_temp1   = AW'(ADDR_TEMP1);
   localparam logic [AW-1:0] c_temp2   = AW'(ADDR_TEMP2);
   localparam logic [AW-1:0] c_temp3   = AW'(ADDR_TEMP3);
   localparam logic [AW-1:0] c_ir      = AW'(ADDR_IR);
   localparam logic [AW-1:0] c_out     = AW'(ADDR_OUT);

   state_e        state_q, state_d;
   logic [DW-1:0] gpr_q  [NUM_GPR];
   logic [DW-1:0] temp_q [4];
   logic [DW-1:0] pc_q, ir_q, out_q;
   logic [3:0]    psr_q;
   logic [AW-1:0] a_lat_q, b_lat_q, c_lat_q;

   logic          w_accept, w_mem_wait, w_cc_op, w_we, w_psr_we;
   logic [AW-1:0] w_addr_a, w_addr_b, w_addr_c, w_rd_a, w_rd_b, w_waddr;
   logic [DW-1:0] w_ir_fld, w_alu_res, w_wdata;
   logic [3:0]    w_alu_flags, w_psr_wdata;

   function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] addr);
      logic [DW-1:0] v;
      v = '0;
      case (addr)
         c_pc:    v = pc_q;
         c_temp0: v = temp_q[0];
         c_temp1: v = temp_q[1];
         c_temp2: v = temp_q[2];
         c_temp3: v = temp_q[3];
         c_ir:    v = ir_q;
         c_out:   v = out_q;
         default: if (addr != '0 && addr < c_num_gpr) v = gpr_q[addr[GW-1:0]];
      endcase
      return v;
   endfunction

   assign w_mem_wait = (state_q == ST_MEM_WAIT);
   assign w_accept   = ARCDP_Cmd_Valid_In && ARCDP_Cmd_Ready_Out;
   assign w_cc_op    = (ARCDP_ALUOperation_InBus[DATAWIDTH_ALU_SELECTION-1:2] == '0);

   // IR fields are zero-extended register numbers
   assign w_addr_a = ARCDP_SelectA_In ? {{(AW-5){1'b0}}, w_ir_fld[18:14]} : ARCDP_DirA_InBus;
   assign w_addr_b = ARCDP_SelectB_In ? {{(AW-5){1'b0}}, w_ir_fld[4:0]}   : ARCDP_DirB_InBus;
   assign w_addr_c = ARCDP_SelectC_In ? {{(AW-5){1'b0}}, w_ir_fld[29:25]} : ARCDP_DirC_InBus;
   assign w_rd_a   = w_mem_wait ? a_lat_q : w_addr_a;
   assign w_rd_b   = w_mem_wait ? b_lat_q : w_addr_b;

`ifdef ARCDP_ALU_PIPE_EN
   logic          ex_wr_q, ex_cc_q;
   logic [AW-1:0] ex_addr_q;
   logic [DW-1:0] ex_res_q;
   logic [3:0]    ex_flags_q;
   logic          w_c_writable;

   assign w_c_writable = (w_addr_c != '0) &&
                         ((w_addr_c < c_num_gpr) || (w_addr_c >= c_pc && w_addr_c <= c_out));
   assign w_ir_fld     = (ex_wr_q && ex_addr_q == c_ir) ? ex_res_q : ir_q;
   assign ARCDP_A_OutBus = (ex_wr_q && ex_addr_q == w_rd_a) ? ex_res_q : rf_read(w_rd_a);
   assign ARCDP_B_OutBus = (ex_wr_q && ex_addr_q == w_rd_b) ? ex_res_q : rf_read(w_rd_b);

   always_ff @(posedge ARCDP_CLOCK_50) begin
      if (ARCDP_ResetInHigh_In) begin
         ex_wr_q    <= 1'b0;
         ex_cc_q    <= 1'b0;
         ex_addr_q  <= '0;
         ex_res_q   <= '0;
         ex_flags_q <= '0;
      end else begin
         ex_wr_q    <= w_accept && !ARCDP_RD_In && w_c_writable;
         ex_cc_q    <= w_accept && !ARCDP_RD_In && w_cc_op;
         ex_addr_q  <= w_addr_c;
         ex_res_q   <= w_alu_res;
         ex_flags_q <= w_alu_flags;
      end
   end

   // EX always drains before a read can complete, so the two writers never collide
   assign w_we        = ex_wr_q || (w_mem_wait && ARCDP_MemValid_In);
   assign w_waddr     = ex_wr_q ? ex_addr_q : c_lat_q;
   assign w_wdata     = ex_wr_q ? ex_res_q : ARCDP_MemoryData_InBus;
   assign w_psr_we    = ex_cc_q;
   assign w_psr_wdata = ex_flags_q;
`else
   assign w_ir_fld       = ir_q;
   assign ARCDP_A_OutBus = rf_read(w_rd_a);
   assign ARCDP_B_OutBus = rf_read(w_rd_b);
   assign w_we        = (w_accept && !ARCDP_RD_In) || (w_mem_wait && ARCDP_MemValid_In);
   assign w_waddr     = w_mem_wait ? c_lat_q : w_addr_c;
   assign w_wdata     = w_mem_wait ? ARCDP_MemoryData_InBus : w_alu_res;
   assign w_psr_we    = w_accept && !ARCDP_RD_In && w_cc_op;
   assign w_psr_wdata = w_alu_flags;
`endif

   arcdp_alu #(.DW(DW)) u_alu (
      .a_i      (ARCDP_A_OutBus),
      .b_i      (ARCDP_B_OutBus),
      .op_i     (alu_op_e'(ARCDP_ALUOperation_InBus)),
      .result_o (w_alu_res),
      .flags_o  (w_alu_flags)
   );

   always_comb begin
      state_d             = state_q;
      ARCDP_Cmd_Ready_Out = 1'b0;
      ARCDP_MemReq_Out    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ARCDP_Cmd_Ready_Out = !ARCDP_ResetInHigh_In;
            if (w_accept && ARCDP_RD_In) state_d = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            ARCDP_MemReq_Out = !ARCDP_ResetInHigh_In;
            if (ARCDP_MemValid_In) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ARCDP_CLOCK_50) begin
      if (ARCDP_ResetInHigh_In) begin
         state_q <= ST_IDLE;
         a_lat_q <= '0;
         b_lat_q <= '0;
         c_lat_q <= '0;
      end else begin
         state_q <= state_d;
         if (w_accept && ARCDP_RD_In) begin
            a_lat_q <= w_addr_a;
            b_lat_q <= w_addr_b;
            c_lat_q <= w_addr_c;
         end
      end
   end

   always_ff @(posedge ARCDP_CLOCK_50) begin
      if (ARCDP_ResetInHigh_In) begin
         for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
         for (int i = 0; i < 4; i++) temp_q[i] <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         out_q <= '0;
         psr_q <= '0;
      end else begin
         if (w_we) begin
            case (w_waddr)
               c_pc:    pc_q      <= w_wdata;
               c_temp0: temp_q[0] <= w_wdata;
               c_temp1: temp_q[1] <= w_wdata;
               c_temp2: temp_q[2] <= w_wdata;
               c_temp3: temp_q[3] <= w_wdata;
               c_ir:    ir_q      <= w_wdata;
               c_out:   out_q     <= w_wdata;
               default: if (w_waddr != '0 && w_waddr < c_num_gpr) gpr_q[w_waddr[GW-1:0]] <= w_wdata;
            endcase
         end
         if (w_psr_we) psr_q <= w_psr_wdata;
      end
   end

   assign ARCDP_PSR_OutBus     = psr_q;
   assign ARCDP_IR_OutBus      = ir_q;
   assign ARCDP_DataOut_OutBus = out_q;

endmodule
`default_nettype wire

// File: tb/tb_arcdp_datapath_gen2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arcdp_datapath_gen2: directed stimulus with queued expectations         |
// | Revision: 2.0                                                              |
// +----------------------------------------------------------------------------+
module tb_arcdp_datapath_gen2;

   localparam int K_ABUS = 0, K_PSR = 1, K_IR = 2, K_READY = 3, K_MEMREQ = 4, K_OUT = 5;

   typedef struct packed {
      logic [95:0] name;
      logic [3:0]  kind;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic        clk = 1'b0;
   logic        rst, valid, ready, sel_a, sel_b, sel_c, rd, mem_valid, mem_req;
   logic [5:0]  dir_a, dir_b, dir_c;
   logic [3:0]  op, psr;
   logic [31:0] mem_data, a_bus, b_bus, ir, dout;

   always #5 clk = ~clk;

   arcdp_datapath_gen2 dut (
      .ARCDP_CLOCK_50           (clk),
      .ARCDP_ResetInHigh_In     (rst),
      .ARCDP_Cmd_Valid_In       (valid),
      .ARCDP_Cmd_Ready_Out      (ready),
      .ARCDP_DirA_InBus         (dir_a),
      .ARCDP_DirB_InBus         (dir_b),
      .ARCDP_DirC_InBus         (dir_c),
      .ARCDP_SelectA_In         (sel_a),
      .ARCDP_SelectB_In         (sel_b),
      .ARCDP_SelectC_In         (sel_c),
      .ARCDP_ALUOperation_InBus (op),
      .ARCDP_RD_In              (rd),
      .ARCDP_MemValid_In        (mem_valid),
      .ARCDP_MemoryData_InBus   (mem_data),
      .ARCDP_MemReq_Out         (mem_req),
      .ARCDP_A_OutBus           (a_bus),
      .ARCDP_B_OutBus           (b_bus),
      .ARCDP_PSR_OutBus         (psr),
      .ARCDP_IR_OutBus          (ir),
      .ARCDP_DataOut_OutBus     (dout)
   );

   // Monitor: compares every queued expectation against the DUT at the falling edge
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         case (int'(e.kind))
            K_ABUS:   act = a_bus;
            K_PSR:    act = {28'd0, psr};
            K_IR:     act = ir;
            K_READY:  act = {31'd0, ready};
            K_MEMREQ: act = {31'd0, mem_req};
            K_OUT:    act = dout;
            default:  act = 32'hxxxx_xxxx;
         endcase
         n_cmp++;
         if (act !== e.val) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input logic [95:0] nm, input int k, input logic [31:0] v);
      exp_t e;
      e.name = nm;
      e.kind = 4'(k);
      e.val  = v;
      sb_q.push_back(e);
   endtask

   task automatic probe(input logic [95:0] nm, input logic [5:0] addr, input logic [31:0] v);
      valid = 1'b0;
      sel_a = 1'b0;
      dir_a = addr;
      expect_v(nm, K_ABUS, v);
      tick();
   endtask

   task automatic settle();
      valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic alu(input logic [3:0] o, input logic [5:0] a, input logic [5:0] b,
                      input logic [5:0] c, input logic sel);
      op = o; dir_a = a; dir_b = b; dir_c = c;
      sel_a = sel; sel_b = sel; sel_c = sel;
      rd = 1'b0; valid = 1'b1;
      expect_v("cmd_ready", K_READY, 1);
      tick();
      valid = 1'b0; sel_a = 1'b0; sel_b = 1'b0; sel_c = 1'b0;
   endtask

   task automatic mem_load(input logic [5:0] c, input logic [31:0] d);
      dir_c = c; sel_c = 1'b0; rd = 1'b1; valid = 1'b1;
      tick();
      valid = 1'b0; rd = 1'b0;
      mem_valid = 1'b1; mem_data = d;
      tick();
      mem_valid = 1'b0;
   endtask

   initial begin
      #100000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      rst = 1'b1; valid = 1'b0; rd = 1'b0; mem_valid = 1'b0; mem_data = '0; op = '0;
      dir_a = '0; dir_b = '0; dir_c = '0; sel_a = 1'b0; sel_b = 1'b0; sel_c = 1'b0;
      tick();
      expect_v("rst_ready", K_READY, 0);
      expect_v("rst_memreq", K_MEMREQ, 0);
      tick();
      rst = 1'b0;
      expect_v("rst_psr", K_PSR, 0);
      expect_v("rst_ir", K_IR, 0);
      expect_v("rst_out", K_OUT, 0);
      expect_v("idle_ready", K_READY, 1);
      probe("rst_r1", 6'd1, 32'd0);

      mem_load(6'd1, 32'd5);
      mem_load(6'd3, 32'h7FFF_FFFF);
      mem_load(6'd4, 32'd1);
      probe("load_r1", 6'd1, 32'd5);

      alu(4'd3, 6'd3, 6'd4, 6'd7, 1'b0);            // ADDCC r7 = r3 + r4
      settle();
      expect_v("addcc_psr", K_PSR, 32'hA);
      probe("addcc_r7", 6'd7, 32'h8000_0000);

      alu(4'd8, 6'd1, 6'd1, 6'd2, 1'b0);            // ADD r2 = r1 + r1
      settle();
      expect_v("add_psr", K_PSR, 32'hA);
      probe("add_r2", 6'd2, 32'd10);

      mem_load(6'd0, 32'h0000_FFFF);
      probe("r0_zero", 6'd0, 32'd0);
      mem_load(6'd40, 32'h0000_1234);
      probe("unmapped", 6'd40, 32'd0);
      expect_v("unm_out", K_OUT, 0);
      probe("unm_r1", 6'd1, 32'd5);

      // stalled read into IR; A bus must hold the latched address
      dir_a = 6'd1; dir_c = 6'd37; rd = 1'b1; valid = 1'b1;
      tick();
      valid = 1'b0; rd = 1'b0; dir_a = 6'd2;
      for (int i = 0; i < 3; i++) begin
         expect_v("wait_ready", K_READY, 0);
         expect_v("wait_memreq", K_MEMREQ, 1);
         expect_v("wait_abus", K_ABUS, 32'd5);
         tick();
      end
      mem_valid = 1'b1; mem_data = 32'h8A00_4005;
      tick();
      mem_valid = 1'b0;
      expect_v("ir_load", K_IR, 32'h8A00_4005);
      expect_v("ir_ready", K_READY, 1);
      expect_v("ir_memreq", K_MEMREQ, 0);
      tick();

      mem_load(6'd37, 32'h0601_0005);               // rd 3, rs1 4, rs2 5
      alu(4'd1, 6'd0, 6'd0, 6'd0, 1'b1);            // ORCC via IR fields
      settle();
      expect_v("orcc_psr", K_PSR, 32'h0);
      probe("orcc_r3", 6'd3, 32'd1);
      mem_load(6'd4, 32'd0);
      alu(4'd1, 6'd0, 6'd0, 6'd0, 1'b1);
      settle();
      expect_v("orcc_z_psr", K_PSR, 32'h4);
      probe("orcc_z_r3", 6'd3, 32'd0);

      mem_load(6'd6, 32'h0001_1F00);
      mem_load(6'd8, 32'd4);
      alu(4'd12, 6'd6, 6'd0, 6'd33, 1'b0);          // SEXT13 -> TEMP0
      alu(4'd4, 6'd6, 6'd8, 6'd38, 1'b0);           // SRL -> OUT
      settle();
      expect_v("srl_out", K_OUT, 32'h0000_11F0);
      expect_v("sext_psr", K_PSR, 32'h4);
      probe("sext_temp0", 6'd33, 32'hFFFF_FF00);

      // read and write of r2 in the same cycle: bus shows the old value
      op = 4'd13; dir_a = 6'd2; dir_c = 6'd2; rd = 1'b0; valid = 1'b1;
      expect_v("rw_old", K_ABUS, 32'd10);
      tick();
      settle();
      probe("rw_new", 6'd2, 32'd11);

      // reset while a read is outstanding
      dir_a = 6'd0; dir_c = 6'd1; rd = 1'b1; valid = 1'b1;
      tick();
      valid = 1'b0; rd = 1'b0;
      expect_v("abort_memreq", K_MEMREQ, 1);
      tick();
      rst = 1'b1;
      expect_v("abort_rdy_rst", K_READY, 0);
      tick();
      rst = 1'b0; mem_valid = 1'b1; mem_data = 32'h0000_DEAD;
      expect_v("abort_ready", K_READY, 1);
      expect_v("abort_memreq0", K_MEMREQ, 0);
      tick();
      mem_valid = 1'b0;
      probe("abort_r1", 6'd1, 32'd0);

      // back-to-back dependent ALU commands
      mem_load(6'd5, 32'd7);
      alu(4'd13, 6'd5, 6'd0, 6'd5, 1'b0);           // INC r5
      alu(4'd8, 6'd5, 6'd5, 6'd6, 1'b0);            // ADD r6 = r5 + r5
      settle();
      probe("b2b_r5", 6'd5, 32'd8);
      probe("b2b_r6", 6'd6, 32'd16);

      valid = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
      dir_a = 6'd6; dir_b = 6'd5;
      #1;
      n_cmp++;
      if (a_bus !== 32'd16) begin
         n_bad++;
         $display("FAIL final_abus: got %h, expected %h", a_bus, 32'd16);
      end
      n_cmp++;
      if (b_bus !== 32'd8) begin
         n_bad++;
         $display("FAIL final_bbus: got %h, expected %h", b_bus, 32'd8);
      end
      n_cmp++;
      if (ready !== 1'b1) begin
         n_bad++;
         $display("FAIL final_ready: got %b, expected 1", ready);
      end
      n_cmp++;
      if (mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL final_memreq: got %b, expected 0", mem_req);
      end

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arcdp_datapath_gen2.md
# arcdp_datapath_gen2

Second-generation ARC microarchitecture datapath: parametrised scratchpad register file, 16-operation ALU with a latched PSR, and a stall-capable memory-read path driven by a valid/ready microinstruction handshake. It sits between the control unit (MIR fields in) and main memory (address/data out, read data in). It replaces the fixed 14-register, single-cycle datapath. Scratchpad addresses for rs1, rs2 and rd are taken from a real IR register, not from the A bus.

## Interface
- NUM_GPR, 32: general registers r0..NUM_GPR-1; legal range 8..32; r0 reads 0.
- DATAWIDTH_BUS, 32: data width; minimum 32, because IR fields sit up to bit 29.
- DATAWIDTH_MIR_DIRECTION, 6: register address width.
- DATAWIDTH_ALU_SELECTION, 4: ALU opcode width.

Ports:
- ARCDP_CLOCK_50  in  1  single clock.
- ARCDP_ResetInHigh_In  in  1  synchronous, active-high reset.
- ARCDP_Cmd_Valid_In  in  1  microinstruction valid.
- ARCDP_Cmd_Ready_Out  out  1  datapath can accept.
- ARCDP_DirA_InBus / DirB / DirC  in  6 each  MIR register addresses.
- ARCDP_SelectA_In / SelectB / SelectC  in  1 each  1 = use IR field (rs1 IR[18:14], rs2 IR[4:0], rd IR[29:25], zero-extended).
- ARCDP_ALUOperation_InBus  in  4  ALU op.
- ARCDP_RD_In  in  1  C-bus source is memory.
- ARCDP_MemValid_In  in  1  read data valid.
- ARCDP_MemoryData_InBus  in  DATAWIDTH_BUS  read data.
- ARCDP_MemReq_Out  out  1  read outstanding.
- ARCDP_A_OutBus / ARCDP_B_OutBus  out  DATAWIDTH_BUS  A/B buses; A is the memory address.
- ARCDP_PSR_OutBus  out  4  {N,Z,V,C}.
- ARCDP_IR_OutBus  out  DATAWIDTH_BUS  instruction register.
- ARCDP_DataOut_OutBus  out  DATAWIDTH_BUS  output register.

## Operation
- Address map:
  - 0..NUM_GPR-1 are general registers.
  - 32 = PC, 33..36 = TEMP0..3, 37 = IR, 38 = OUT.
  - Unmapped addresses, and r0, read 0 and ignore writes.
- ALU ops, 0..15: ANDCC, ORCC, NORCC, ADDCC, SRL, AND, OR, NOR, ADD, LSHIFT2, LSHIFT10, SIMM13, SEXT13, INC, INCPC, RSHIFT5.
  - Ops 0..3 update the PSR; all other ops leave it unchanged.
  - N = result MSB; Z = result == 0.
  - ADDCC: C = carry out, V = signed overflow. Logical CC ops: V = C = 0.
  - SRL shifts A by B[4:0]. INCPC adds 4. SIMM13/SEXT13 use A[12:0], zero-extended/sign-extended respectively.
- FSM states:
  - IDLE: Ready = 1 (except during reset).
    - Accept a command on Valid & Ready.
    - RD = 0: the ALU result on the A/B buses is written to the C address at the accepting edge. Stay in IDLE.
    - RD = 1: latch the resolved A/B/C addresses and go to MEM_WAIT.
  - MEM_WAIT: Ready = 0, MemReq = 1. The A/B buses are driven from the latched addresses, held stable.
    - On MemValid, write MemoryData to the latched C address and return to IDLE.
- In IDLE, the A/B buses follow the live Dir/Select inputs combinationally.
- Boundary behaviour:
  - MemValid in IDLE is ignored.
  - C = 0 means no write.
  - A read and a write of the same register in the same cycle: the read sees the old value (no macro).
  - Reset during MEM_WAIT aborts the read, and a late MemValid is then ignored.
- Reset values: all registers, PSR and OUT are 0; state is IDLE; MemReq = 0; Ready = 0 while reset is high.

## Timing
- ALU command, no macro: result is visible in the register file and PSR one edge after acceptance.
- Memory read: latency is 1 cycle after the MemValid edge. Ready re-asserts the cycle after MemValid.
- Back-to-back ALU commands are accepted every cycle.

## Configuration
- ARCDP_ALU_PIPE_EN defined:
  - ALU result, destination address and flags are registered (EX stage) and written to the register file one cycle later.
  - Forwarding covers A/B reads and IR-field selection: an EX destination equal to a read address, or an EX destination of IR, forwards the pending value.
  - The PSR updates at write-back. An RD command accepted while EX is pending still drains EX on the next edge.
  - Throughput is unchanged; register/PSR latency becomes 2 edges.
- Not defined: single-cycle write-back as described in Operation.

## Structure
- arcdp_pkg holds:
  - the ALU opcode enum;
  - the special-register address constants (PC, TEMP0..3, IR, OUT);
  - the PSR bit indices;
  - the FSM state enum.
- The sub-module arcdp_alu (combinational; result plus N/Z/V/C) is instantiated once.

## Test plan
- Reset, then ADD with A = r1 (written 5 earlier) and B = r1, C = r2 -> r2 = 10, PSR unchanged. ADDCC with 0x7FFFFFFF + 1 -> result 0x80000000, PSR = 4'b1010.
- Write C = 0 with 0xFFFF -> r0 still reads 0. Write to address 40 -> no register changes.
- RD command, MemValid delayed 3 cycles with data 0x8A00_4005 to IR -> Ready low for 3 cycles, IR updated, MemReq falls with Ready rising.
- IR = rd 3 / rs1 4 / rs2 5 via select lines, ORCC -> r3 = r4 | r5, Z set when both are 0.
- Reset asserted in MEM_WAIT, then MemValid -> no write; state IDLE; Ready = 1 after reset is released.
- With ARCDP_ALU_PIPE_EN: INC r5 followed immediately by ADD r6 = r5 + r5 -> forwarded result; r6 = 2×(r5+1).
